vga_sync_receiver: RTL and testbench
====================================

// Module: vga_sync_receiver
// PURPOSE
//  Sink-side counterpart of the on-chip VGA timing generator: samples an incoming hsync/vsync pair,
//  checks it against the 640x480@60 timing the demo emits, and regenerates locked pixel coordinates
//  and display_on. Used to loop back / self-check the TinyVGA output and to genlock effects to an
//  external sync source.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_BACK     48   clocks from hsync deassertion to first visible pixel
//  H_TOTAL    800  clocks per line
//  V_ACTIVE   480  visible lines per frame
//  V_BACK     33   lines from vsync deassertion to first visible line
//  V_TOTAL    525  lines per frame
//  SYNC_POL   0    sync active level (0 = active-low, 1 = active-high), applies to both syncs
//  TIMEOUT    1600 clocks without an hsync trailing edge before loss of lock (2*H_TOTAL)
// PORTS
//  clk         in   1   pixel clock (25 MHz)
//  rst_n       in   1   reset, asynchronous, active-low
//  hsync_in    in   1   horizontal sync from source
//  vsync_in    in   1   vertical sync from source
//  locked      out  1   timing verified; coordinates valid
//  display_on  out  1   current pixel visible (only when locked)
//  hpos        out  10  visible x, 0..H_ACTIVE-1 (0 when not visible)
//  vpos        out  10  visible y, 0..V_ACTIVE-1 (0 when not visible)
//  frame_start out  1   1-clk pulse at hpos=0,vpos=0 visible pixel (locked only)
//  err_cnt     out  8   lock-loss events, saturates at 255
// BEHAVIOUR
//  - One clock, one reset: clk, rst_n asynchronous active-low. All outputs registered; reset: locked=0,
//    display_on=0, hpos=0, vpos=0, frame_start=0, err_cnt=0, FSM=SEARCH, all counters 0.
//  - Inputs registered once (hs_q, vs_q); trailing edge = hs_q active & hsync_in inactive (same for vs).
//  - h_cnt (10b): cleared to 0 in cycle after an h trailing edge, else +1, saturates at 1023.
//  - v_cnt (10b): on each h trailing edge: cleared if a v trailing edge occurred since previous h edge,
//    else +1 (saturate 1023). v edge alone does not touch v_cnt.
//  - line check at each h trailing edge: good iff h_cnt == H_TOTAL-1 (line of exactly H_TOTAL clks).
//    First h edge after SEARCH entry is not checked. frame check at v trailing edge: good iff
//    v_cnt == V_TOTAL-1 and no bad line since previous v edge.
//  - FSM: SEARCH -> MEASURE on first v trailing edge (clears bad-line flag).
//    MEASURE -> LOCKED on next v trailing edge if frame good; else stay MEASURE, flag cleared.
//    LOCKED -> SEARCH on bad line (same edge), bad frame, or TIMEOUT clks with no h edge;
//    err_cnt +1 (sat) on each LOCKED->SEARCH. MEASURE/SEARCH timeout -> SEARCH, no err increment.
//  - locked = (state==LOCKED), updated cycle after the deciding edge.
//  - visible iff locked & H_BACK<=h_cnt<H_BACK+H_ACTIVE & V_BACK<=v_cnt<V_BACK+V_ACTIVE;
//    hpos=h_cnt-H_BACK, vpos=v_cnt-V_BACK registered from that h_cnt/v_cnt: output latency
//    is 1 clk after counter state; display_on/hpos/vpos always mutually consistent.
//  - frame_start asserted with the hpos=0,vpos=0 output cycle.
//  - Simultaneous h and v trailing edges in same clk: v edge recorded first, so that h edge clears v_cnt.
//  - Sync asserted longer than TIMEOUT treated as missing sync. rst_n low mid-frame: immediate return
//    to reset values; relock requires two full frames again. err_cnt cleared only by reset.
// TESTING
//  1 Ideal 800x525 timing, SYNC_POL=0 -> locked=1 one clk after 2nd vsync trailing edge; next frame
//    display_on high exactly 640 clks/line x 480 lines, hpos 0..639, frame_start once per frame.
//  2 While locked inject one 799-clk line -> locked=0 cycle after that h edge, err_cnt 0->1,
//    display_on 0; relock after two further good frames.
//  3 Frame of 524 lines while locked -> unlock at v edge, err_cnt+1; MEASURE frame of 526 lines
//    -> remains MEASURE, err_cnt unchanged.
//  4 hsync held active 1600 clks while locked -> locked=0 at timeout, err_cnt+1, hpos/vpos=0.
//  5 Pulse rst_n low mid-visible-line (async, between edges) -> all outputs 0 immediately, err_cnt=0.
//  6 Force 256 lock losses -> err_cnt holds 255; SYNC_POL=1 with inverted syncs -> same as test 1.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//   Sink-side checker for the 640x480@60 VGA timing. It samples an incoming
//   hsync/vsync pair and verifies line and frame lengths. Once two consecutive
//   trailing vsync edges bracket a correct frame, it regenerates pixel
//   coordinates locked to the source.
//
// Ports
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   hsync_in    horizontal sync from the source (active level = SYNC_POL)
//   vsync_in    vertical sync from the source (active level = SYNC_POL)
//   locked      timing verified, coordinates valid
//   display_on  current output pixel is visible (only while locked)
//   hpos, vpos  visible coordinates, 0 whenever display_on is low
//   frame_start one-cycle pulse with the hpos=0,vpos=0 pixel
//   err_cnt     number of lock losses, saturating at 255
module vga_sync_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int H_BACK   = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_BACK   = 33,
  parameter int V_TOTAL  = 525,
  parameter bit SYNC_POL = 1'b0,
  parameter int TIMEOUT  = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       locked,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       frame_start,
  output logic [7:0] err_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [9:0]    H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_LO    = 10'(H_BACK);
  localparam logic [9:0]    H_HI    = 10'(H_BACK + H_ACTIVE);
  localparam logic [9:0]    V_LO    = 10'(V_BACK);
  localparam logic [9:0]    V_HI    = 10'(V_BACK + V_ACTIVE);
  localparam logic [9:0]    CNT_MAX = 10'h3FF;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t        state;
  logic          hs_q, vs_q;
  logic [9:0]    h_cnt, v_cnt;
  logic          v_seen;
  logic          bad_seen;
  logic          h_skip;
  logic [TW-1:0] to_cnt;

  logic hs_act, vs_act;
  logic h_edge, v_edge;
  logic line_bad, frame_good, timeout, vis;

  // The sync registers hold "sync is active", not the raw pin level, so the
  // reset value 0 can never fake a trailing edge whatever SYNC_POL is.
  assign hs_act = (hsync_in == SYNC_POL);
  assign vs_act = (vsync_in == SYNC_POL);
  assign h_edge = hs_q & ~hs_act;
  assign v_edge = vs_q & ~vs_act;

  assign line_bad   = h_edge && !h_skip && (h_cnt != H_LAST);
  assign frame_good = (v_cnt == V_LAST) && !bad_seen;
  assign timeout    = !h_edge && (to_cnt == TO_LAST);

  assign vis = (state == LOCKED) &&
               (h_cnt >= H_LO) && (h_cnt < H_HI) &&
               (v_cnt >= V_LO) && (v_cnt < V_HI);

  // Sync sampling and line/frame counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
      v_seen <= 1'b0;
      to_cnt <= '0;
    end else begin
      hs_q <= hs_act;
      vs_q <= vs_act;

      if (h_edge) begin
        h_cnt  <= '0;
        to_cnt <= '0;
      end else begin
        if (h_cnt != CNT_MAX) h_cnt <= h_cnt + 10'd1;
        if (to_cnt != TO_LAST) to_cnt <= to_cnt + TW'(1);
      end

      // A v edge in the same clock as an h edge counts as already seen,
      // so that h edge starts line 0.
      if (h_edge) begin
        v_seen <= 1'b0;
        if (v_seen || v_edge)    v_cnt <= '0;
        else if (v_cnt != CNT_MAX) v_cnt <= v_cnt + 10'd1;
      end else if (v_edge) begin
        v_seen <= 1'b1;
      end
    end
  end

  // Lock FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      locked   <= 1'b0;
      err_cnt  <= '0;
      h_skip   <= 1'b1;
      bad_seen <= 1'b0;
    end else begin
      bad_seen <= v_edge ? 1'b0 : (bad_seen | line_bad);
      if (h_edge) h_skip <= 1'b0;

      case (state)
        SEARCH: begin
          if (timeout) begin
            h_skip <= 1'b1;
          end else if (v_edge) begin
            state  <= MEASURE;
            locked <= 1'b0;
          end
        end
        MEASURE: begin
          if (timeout) begin
            state  <= SEARCH;
            locked <= 1'b0;
            h_skip <= 1'b1;
          end else if (v_edge && frame_good) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (line_bad || (v_edge && !frame_good) || timeout) begin
            state  <= SEARCH;
            locked <= 1'b0;
            h_skip <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
          h_skip <= 1'b1;
        end
      endcase
    end
  end

  // Coordinate outputs, one clock behind the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_on  <= 1'b0;
      hpos        <= '0;
      vpos        <= '0;
      frame_start <= 1'b0;
    end else begin
      display_on  <= vis;
      hpos        <= vis ? (h_cnt - H_LO) : '0;
      vpos        <= vis ? (v_cnt - V_LO) : '0;
      frame_start <= vis && (h_cnt == H_LO) && (v_cnt == V_LO);
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Testbench for vga_sync_receiver, using scaled-down timing so that many frames fit in a short run.
// Two instances run side by side on the same logical sync stream:
//   - u_dut0 uses SYNC_POL=0 and receives the inverted syncs.
//   - u_dut1 uses SYNC_POL=1 and receives the syncs as-is.
// Each line and frame ends with its sync pulse, so the trailing edges land on pixel 0 of line 0.
module tb_vga_sync_receiver;

  localparam int HA = 4, HB = 1, HT = 8;
  localparam int VA = 3, VB = 1, VT = 6;
  localparam int TO = 16, HS_W = 2, VS_W = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs_act = 1'b0, vs_act = 1'b0;
  logic hs0, vs0, hs1, vs1;

  logic       lk0, dp0, fs0, lk1, dp1, fs1;
  logic [9:0] hp0, vp0, hp1, vp1;
  logic [7:0] ec0, ec1;

  assign hs0 = ~hs_act;
  assign vs0 = ~vs_act;
  assign hs1 = hs_act;
  assign vs1 = vs_act;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BACK(VB), .V_TOTAL(VT),
    .SYNC_POL(1'b0), .TIMEOUT(TO)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hsync_in(hs0), .vsync_in(vs0),
    .locked(lk0), .display_on(dp0), .hpos(hp0), .vpos(vp0),
    .frame_start(fs0), .err_cnt(ec0)
  );

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BACK(VB), .V_TOTAL(VT),
    .SYNC_POL(1'b1), .TIMEOUT(TO)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hsync_in(hs1), .vsync_in(vs1),
    .locked(lk1), .display_on(dp1), .hpos(hp1), .vpos(vp1),
    .frame_start(fs1), .err_cnt(ec1)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // expected pixel stream {frame_start, vpos, hpos}, one queue per instance
  logic [20:0] q0[$];
  logic [20:0] q1[$];

  // locked as seen just before driving pixel 0 (pre) and pixel 1 (post) of each line
  logic lk_pre0[16], lk_post0[16], lk_pre1[16], lk_post1[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk2(input string nm, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] exp);
    chk({nm, "/pol0"}, a0, exp);
    chk({nm, "/pol1"}, a1, exp);
  endtask

  task automatic chk_all_zero(input string nm);
    chk2({nm, " locked"},      32'(lk0), 32'(lk1), 32'd0);
    chk2({nm, " display_on"},  32'(dp0), 32'(dp1), 32'd0);
    chk2({nm, " hpos"},        32'(hp0), 32'(hp1), 32'd0);
    chk2({nm, " vpos"},        32'(vp0), 32'(vp1), 32'd0);
    chk2({nm, " frame_start"}, 32'(fs0), 32'(fs1), 32'd0);
    chk2({nm, " err_cnt"},     32'(ec0), 32'(ec1), 32'd0);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async reset");
    #1 rst_n = 1'b1;
  endtask

  // One frame of `lines` lines; line `short_line` is one clock short.
  // The first `npix` visible pixels are expected on the output.
  // When rst_at >= 0, reset is pulsed after that clock index of the frame.
  task automatic send_frame(input int lines, input int short_line, input int npix,
                            input int rst_at);
    int idx;
    int pushed;
    int len;
    logic [20:0] e;
    idx = 0;
    pushed = 0;
    for (int l = VB; l < VB + VA; l++) begin
      for (int x = 0; x < HA; x++) begin
        if (pushed < npix) begin
          e[20]    = (l == VB) && (x == 0);
          e[19:10] = 10'(l - VB);
          e[9:0]   = 10'(x);
          q0.push_back(e);
          q1.push_back(e);
          pushed++;
        end
      end
    end
    for (int l = 0; l < lines; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        @(negedge clk);
        if (l < 16 && p == 0) begin lk_pre0[l] = lk0;  lk_pre1[l] = lk1;  end
        if (l < 16 && p == 1) begin lk_post0[l] = lk0; lk_post1[l] = lk1; end
        hs_act = (p >= len - HS_W);
        vs_act = (l >= lines - VS_W);
        if (idx == rst_at) reset_pulse();
        idx++;
      end
    end
  endtask

  task automatic sync_hold(input int n);
    repeat (n) begin
      @(negedge clk);
      hs_act = 1'b1;
      vs_act = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      hs_act = 1'b0;
      vs_act = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (dp0) begin
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL pixel/pol0: got unexpected pixel hpos=%0d vpos=%0d expected none", hp0, vp0);
        end else if ({fs0, vp0, hp0} !== q0[0]) begin
          errors++;
          $display("FAIL pixel/pol0: got fs=%0d vpos=%0d hpos=%0d expected fs=%0d vpos=%0d hpos=%0d",
                   fs0, vp0, hp0, q0[0][20], q0[0][19:10], q0[0][9:0]);
          void'(q0.pop_front());
        end else begin
          void'(q0.pop_front());
        end
      end else if (hp0 != 10'd0 || vp0 != 10'd0 || fs0 != 1'b0) begin
        errors++;
        $display("FAIL blank/pol0: got fs=%0d vpos=%0d hpos=%0d expected all 0", fs0, vp0, hp0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (dp1) begin
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL pixel/pol1: got unexpected pixel hpos=%0d vpos=%0d expected none", hp1, vp1);
        end else if ({fs1, vp1, hp1} !== q1[0]) begin
          errors++;
          $display("FAIL pixel/pol1: got fs=%0d vpos=%0d hpos=%0d expected fs=%0d vpos=%0d hpos=%0d",
                   fs1, vp1, hp1, q1[0][20], q1[0][19:10], q1[0][9:0]);
          void'(q1.pop_front());
        end else begin
          void'(q1.pop_front());
        end
      end else if (hp1 != 10'd0 || vp1 != 10'd0 || fs1 != 1'b0) begin
        errors++;
        $display("FAIL blank/pol1: got fs=%0d vpos=%0d hpos=%0d expected all 0", fs1, vp1, hp1);
      end
    end
  end

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(3);

    // ideal timing: priming frame, measured frame, then locked frames
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, 0, -1);
    chk2("measure not locked", 32'(lk_post0[0]), 32'(lk_post1[0]), 32'd0);
    send_frame(VT, -1, VA * HA, -1);
    chk2("lock pre edge",  32'(lk_pre0[0]),  32'(lk_pre1[0]),  32'd0);
    chk2("lock post edge", 32'(lk_post0[0]), 32'(lk_post1[0]), 32'd1);
    send_frame(VT, -1, VA * HA, -1);

    // short line 2 while locked: rows 0 and 1 are shown, then lock is lost
    send_frame(VT, 2, 2 * HA, -1);
    chk2("short line pre",  32'(lk_pre0[3]),  32'(lk_pre1[3]),  32'd1);
    chk2("short line post", 32'(lk_post0[3]), 32'(lk_post1[3]), 32'd0);
    chk2("short line err", 32'(ec0), 32'(ec1), 32'd1);
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, VA * HA, -1);
    chk2("relock after line", 32'(lk_post0[0]), 32'(lk_post1[0]), 32'd1);

    // short frame while locked, then a long frame while measuring
    send_frame(VT - 1, -1, VA * HA, -1);
    send_frame(VT, -1, 0, -1);
    chk2("short frame pre",  32'(lk_pre0[0]),  32'(lk_pre1[0]),  32'd1);
    chk2("short frame post", 32'(lk_post0[0]), 32'(lk_post1[0]), 32'd0);
    chk2("short frame err", 32'(ec0), 32'(ec1), 32'd2);
    send_frame(VT + 1, -1, 0, -1);
    send_frame(VT, -1, 0, -1);
    chk2("long frame measure", 32'(lk_post0[0]), 32'(lk_post1[0]), 32'd0);
    chk2("long frame err", 32'(ec0), 32'(ec1), 32'd2);
    send_frame(VT, -1, VA * HA, -1);
    chk2("relock after frame", 32'(lk_post0[0]), 32'(lk_post1[0]), 32'd1);

    // hsync stuck active
    sync_hold(4);
    chk2("hold before timeout", 32'(lk0), 32'(lk1), 32'd1);
    sync_hold(14);
    chk2("hold after timeout", 32'(lk0), 32'(lk1), 32'd0);
    chk2("timeout err", 32'(ec0), 32'(ec1), 32'd3);

    // relock, then reset mid-line after the first visible pixel
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, 0, -1);
    send_frame(VT, -1, 1, HT + 3);
    chk2("locked before reset", 32'(lk_post0[0]), 32'(lk_post1[0]), 32'd1);
    send_frame(VT, -1, 0, -1);
    chk2("measure after reset", 32'(lk_post0[0]), 32'(lk_post1[0]), 32'd0);
    send_frame(VT, -1, VA * HA, -1);
    chk2("relock after reset", 32'(lk_post0[0]), 32'(lk_post1[0]), 32'd1);
    chk2("err after reset", 32'(ec0), 32'(ec1), 32'd0);

    // 256 lock losses: err_cnt saturates
    for (int i = 0; i < 256; i++) begin
      send_frame(VT, 0, 0, -1);
      chk2("loop locked", 32'(lk_post0[0]), 32'(lk_post1[0]), 32'd1);
      chk2("loop lost",   32'(lk_post0[1]), 32'(lk_post1[1]), 32'd0);
      if (i == 0) chk2("loop first err", 32'(ec0), 32'(ec1), 32'd1);
      send_frame(VT, -1, 0, -1);
    end
    chk2("err saturated", 32'(ec0), 32'(ec1), 32'd255);
    send_frame(VT, -1, VA * HA, -1);
    chk2("final locked", 32'(lk_post0[0]), 32'(lk_post1[0]), 32'd1);
    chk2("final err", 32'(ec0), 32'(ec1), 32'd255);

    idle(20);
    chk2("pixels left", 32'(q0.size()), 32'(q1.size()), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
